// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Holds the PC and issues one word read at a time.
// Buffers the returned word and hands instr/PC to decode over valid/ready.
// A redirect from execute reloads the PC. Any fetch still in flight at that
// point becomes stale, and its response is discarded when it arrives.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // ISSUE: send a request.  WAIT: live request outstanding.
    // DROP : stale request outstanding.  HOLD: buffered instruction offered to decode.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] target_pc;

    // Redirect targets are always word aligned.
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // A redirect in the same cycle suppresses the request, so the old PC is never fetched.
    assign imem_req  = (state_q == ISSUE) && !redirect_valid && !rst;
    assign imem_addr = pc_q;
    assign out_valid = (state_q == HOLD);
    assign out_instr = instr_q;
    assign out_pc    = out_pc_q;

    // Next-state and datapath selection for the fetch sequencer.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        case (state_q)
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // The response is stale. If it is already here, drop it now.
                    // Otherwise wait for it in DROP.
                    pc_d    = target_pc;
                    state_d = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    instr_d  = imem_rdata;
                    out_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = HOLD;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = target_pc;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                // Redirect beats out_ready. The buffered instruction is on the wrong path.
                if (redirect_valid) begin
                    pc_d    = target_pc;
                    state_d = ISSUE;
                end else if (out_ready) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= ISSUE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            out_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Directed scenarios come first, then a randomized run.
// The randomized run is checked against a stream-level reference model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    // Memory model: one outstanding read, answered mem_lat cycles after its request.
    logic        pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'h0;
    int          mem_lat   = 1;
    logic        spur_en   = 1'b0;
    logic        resp_real;
    logic        overlap;

    // Outputs observed in the current cycle, sampled 1 ns after the inputs change.
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        if (a == 32'h0000_0004) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // Runs one clock cycle.
    // Drives the memory response and the control inputs on the falling edge,
    // then samples the DUT outputs and records any request for the memory model.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        resp_real   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
                resp_real   = 1'b1;
            end
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = out_valid;
        obs_instr = out_instr;
        obs_pc    = out_pc;
        overlap   = (imem_req === 1'b1) && pend;
        if (imem_req === 1'b1) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = imem_addr;
        end
    endtask

    // Holds reset long enough for any earlier response to drain.
    task automatic do_reset();
        spur_en = 1'b0;
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b1);
            n_vec++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_instr !== NOP_INSTR ||
                obs_pc !== RESET_PC || obs_addr !== RESET_PC) begin
                n_err++;
                $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h addr=%h, want 0 0 %h %h %h",
                         obs_req, obs_valid, obs_instr, obs_pc, obs_addr, NOP_INSTR, RESET_PC, RESET_PC);
            end
        end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_err++; $display("FAIL basic_req0: req=%b addr=%h, want 1 00000000", obs_req, obs_addr);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_wait: req=%b valid=%b, want 0 0", obs_req, obs_valid);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_instr !== 32'h0050_0093 || obs_pc !== 32'h0) begin
            n_err++; $display("FAIL basic_out0: valid=%b instr=%h pc=%h, want 1 00500093 00000000",
                              obs_valid, obs_instr, obs_pc);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h4 || obs_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_req4: req=%b addr=%h valid=%b, want 1 00000004 0",
                              obs_req, obs_addr, obs_valid);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_instr !== 32'h00A0_0113 || obs_pc !== 32'h4) begin
            n_err++; $display("FAIL basic_out4: valid=%b instr=%h pc=%h, want 1 00a00113 00000004",
                              obs_valid, obs_instr, obs_pc);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
            n_err++; $display("FAIL basic_req8: req=%b addr=%h, want 1 00000008", obs_req, obs_addr);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            n_vec++;
            if (obs_valid !== 1'b1 || obs_instr !== 32'h0050_0093 || obs_pc !== 32'h0 || obs_req !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: valid=%b instr=%h pc=%h req=%b, want 1 00500093 00000000 0",
                                  i, obs_valid, obs_instr, obs_pc, obs_req);
            end
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            n_err++; $display("FAIL bp_release: valid=%b req=%b, want 1 0", obs_valid, obs_req);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h4 || obs_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_next_req: req=%b addr=%h valid=%b, want 1 00000004 0",
                              obs_req, obs_addr, obs_valid);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        n_vec++;
        if (obs_req !== 1'b0) begin
            n_err++; $display("FAIL rw_no_req: req=%b, want 0", obs_req);
        end
        // DROP, stale response, then the new request: nothing may be presented.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0 || (i < 2 && obs_req !== 1'b0)) begin
                n_err++; $display("FAIL rw_drop[%0d]: valid=%b req=%b, want 0 0", i, obs_valid, obs_req);
            end
        end
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            n_err++; $display("FAIL rw_req100: req=%b addr=%h, want 1 00000100", obs_req, obs_addr);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_err++; $display("FAIL rw_wait2[%0d]: valid=%b, want 0", i, obs_valid);
            end
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h100 || obs_instr !== mem_word(32'h100)) begin
            n_err++; $display("FAIL rw_out100: valid=%b pc=%h instr=%h, want 1 00000100 %h",
                              obs_valid, obs_pc, obs_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h203, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            n_err++; $display("FAIL rh_hold: valid=%b req=%b, want 1 0", obs_valid, obs_req);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200) begin
            n_err++; $display("FAIL rh_req200: valid=%b req=%b addr=%h, want 0 1 00000200",
                              obs_valid, obs_req, obs_addr);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h200 || obs_instr !== mem_word(32'h200)) begin
            n_err++; $display("FAIL rh_out200: valid=%b pc=%h instr=%h, want 1 00000200 %h",
                              obs_valid, obs_pc, obs_instr, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        n_vec++;
        if (obs_req !== 1'b0) begin
            n_err++; $display("FAIL wrap_suppress: req=%b, want 0", obs_req);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_req_top: req=%b addr=%h, want 1 fffffffc", obs_req, obs_addr);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'hFFFF_FFFC || obs_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_err++; $display("FAIL wrap_out: valid=%b pc=%h instr=%h, want 1 fffffffc %h",
                              obs_valid, obs_pc, obs_instr, mem_word(32'hFFFF_FFFC));
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_req_zero: req=%b addr=%h, want 1 00000000", obs_req, obs_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem_lat = 1;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        mem_lat = 3;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin
            n_err++; $display("FAIL rm_req4: req=%b addr=%h, want 1 00000004", obs_req, obs_addr);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b0 || obs_instr !== NOP_INSTR || obs_pc !== RESET_PC) begin
            n_err++; $display("FAIL rm_in_reset: req=%b valid=%b instr=%h pc=%h, want 0 0 %h %h",
                              obs_req, obs_valid, obs_instr, obs_pc, NOP_INSTR, RESET_PC);
        end
        // The late response to the abandoned fetch arrives in this cycle.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (resp_real !== 1'b1 || obs_req !== 1'b1 || obs_addr !== RESET_PC || obs_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_restart: late_rvalid=%b req=%b addr=%h valid=%b, want 1 1 %h 0",
                              resp_real, obs_req, obs_addr, obs_valid, RESET_PC);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0) begin
                n_err++; $display("FAIL rm_wait[%0d]: valid=%b, want 0", i, obs_valid);
            end
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b1 || obs_pc !== RESET_PC || obs_instr !== mem_word(RESET_PC)) begin
            n_err++; $display("FAIL rm_out: valid=%b pc=%h instr=%h, want 1 %h %h",
                              obs_valid, obs_pc, obs_instr, RESET_PC, mem_word(RESET_PC));
        end
    endtask

    // Randomized run checked against a stream-level model.
    // The model tracks only the address of the next instruction decode must receive.
    // A redirect reloads that address; each accepted transfer advances it by one word.
    task automatic test_random();
        logic [31:0] exp_pc, rpc, prev_instr, prev_pc;
        logic        rv, rdy, xfer, live, pend_live, prev_live, prev_xfer, prev_hold;
        int          n_xfer;
        do_reset();
        exp_pc    = RESET_PC;
        pend_live = 1'b0;
        prev_live = 1'b0;
        prev_xfer = 1'b0;
        prev_hold = 1'b0;
        prev_instr = 32'h0;
        prev_pc    = 32'h0;
        n_xfer    = 0;
        spur_en   = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rv      = ($urandom_range(0, 9) == 0);
            rdy     = ($urandom_range(0, 2) != 0);
            rpc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : ($urandom & 32'h0000_03FF);
            mem_lat = $urandom_range(1, 4);
            cycle(1'b0, rv, rpc, rdy);
            if (prev_live) begin
                n_vec++;
                if (obs_valid !== 1'b1) begin
                    n_err++; $display("FAIL rnd_latency[%0d]: valid=%b, want 1", i, obs_valid);
                end
            end
            if (prev_hold) begin
                n_vec++;
                if (obs_valid !== 1'b1 || obs_instr !== prev_instr || obs_pc !== prev_pc) begin
                    n_err++; $display("FAIL rnd_stable[%0d]: valid=%b instr=%h pc=%h, want 1 %h %h",
                                      i, obs_valid, obs_instr, obs_pc, prev_instr, prev_pc);
                end
            end
            if (prev_xfer && !rv) begin
                n_vec++;
                if (obs_req !== 1'b1) begin
                    n_err++; $display("FAIL rnd_next_req[%0d]: req=%b, want 1", i, obs_req);
                end
            end
            if (obs_req === 1'b1) begin
                n_vec++;
                if (obs_addr !== exp_pc || overlap) begin
                    n_err++; $display("FAIL rnd_req[%0d]: addr=%h overlap=%b, want %h 0",
                                      i, obs_addr, overlap, exp_pc);
                end
            end
            xfer = (obs_valid === 1'b1) && rdy && !rv;
            if (xfer) begin
                n_vec++;
                if (obs_pc !== exp_pc || obs_instr !== mem_word(exp_pc)) begin
                    n_err++; $display("FAIL rnd_xfer[%0d]: pc=%h instr=%h, want %h %h",
                                      i, obs_pc, obs_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            live = resp_real && pend_live && !rv;
            if (rv) pend_live = 1'b0;
            if (obs_req === 1'b1) pend_live = 1'b1;
            prev_live  = live;
            prev_xfer  = xfer;
            prev_hold  = (obs_valid === 1'b1) && !xfer && !rv;
            prev_instr = obs_instr;
            prev_pc    = obs_pc;
            if (rv) exp_pc = {rpc[31:2], 2'b00};
        end
        spur_en = 1'b0;
        n_vec++;
        if (n_xfer < 50) begin
            n_err++; $display("FAIL rnd_progress: transfers=%0d, want at least 50", n_xfer);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
